mul8x8_seq_ctrl: RTL

MUL8X8_SEQ_CTRL -- requirements
Module: mul8x8_seq_ctrl

---
 rtl/mul8x8_seq_ctrl.sv | 137 +++++++++++++
 1 files changed

// File: rtl/mul8x8_seq_ctrl.sv
// Sequential 8x8 unsigned multiplier controller: builds the product from four
// nibble partials issued to one shared 4x4 multiplier of latency MUL_LAT (0 or 1).
module mul8x8_seq_ctrl #(
  parameter int MUL_LAT = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [7:0]  a,
  input  logic [7:0]  b,
  output logic [3:0]  mul_a,
  output logic [3:0]  mul_b,
  input  logic [7:0]  mul_r,
  output logic        mul_en,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] p,
  output logic        ovf,
  output logic        busy
);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t      state;
  logic [1:0]  step;
  logic [1:0]  cap;
  logic [7:0]  a_q;
  logic [7:0]  b_q;
  logic [16:0] acc;
  logic        cap_vld;
  logic        accept;
  logic        cap_now;
  logic [16:0] part;
  logic [16:0] acc_sum;
  logic [3:0]  nxt_a;
  logic [3:0]  nxt_b;

  assign in_ready = (state == IDLE) || ((state == DONE) && out_ready);
  assign accept   = in_valid && in_ready;
  assign busy     = (state != IDLE);

  // With a registered multiplier the partial for step k arrives one cycle
  // after its issue, tracked by cap_vld; otherwise it is captured on issue.
  assign cap_now = (state == CALC) && ((MUL_LAT == 0) ? mul_en : cap_vld);

  always_comb begin
    part = '0;
    case (cap)
      2'd0:    part = {9'd0, mul_r};
      2'd1,
      2'd2:    part = {5'd0, mul_r, 4'd0};
      default: part = {1'b0, mul_r, 8'd0};
    endcase
    acc_sum = acc + part;
  end

  // Operand nibbles for the step following the one currently issued.
  always_comb begin
    nxt_a = a_q[7:4];
    nxt_b = b_q[7:4];
    case (step)
      2'd0:    begin nxt_a = a_q[7:4]; nxt_b = b_q[3:0]; end
      2'd1:    begin nxt_a = a_q[3:0]; nxt_b = b_q[7:4]; end
      default: begin nxt_a = a_q[7:4]; nxt_b = b_q[7:4]; end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      step      <= '0;
      cap       <= '0;
      a_q       <= '0;
      b_q       <= '0;
      acc       <= '0;
      cap_vld   <= 1'b0;
      mul_a     <= '0;
      mul_b     <= '0;
      mul_en    <= 1'b0;
      out_valid <= 1'b0;
      p         <= '0;
      ovf       <= 1'b0;
    end else begin
      cap_vld <= 1'b0;
      if (accept) begin
        // Step 0 is issued in the cycle right after acceptance.
        state     <= CALC;
        a_q       <= a;
        b_q       <= b;
        acc       <= '0;
        step      <= '0;
        cap       <= '0;
        mul_a     <= a[3:0];
        mul_b     <= b[3:0];
        mul_en    <= 1'b1;
        out_valid <= 1'b0;
      end else begin
        case (state)
          CALC: begin
            if (mul_en) begin
              cap_vld <= 1'b1;
              if (step == 2'd3) begin
                mul_en <= 1'b0;
                mul_a  <= '0;
                mul_b  <= '0;
              end else begin
                step  <= step + 2'd1;
                mul_a <= nxt_a;
                mul_b <= nxt_b;
              end
            end
            if (cap_now) begin
              acc <= acc_sum;
              cap <= cap + 2'd1;
              if (cap == 2'd3) begin
                state     <= DONE;
                out_valid <= 1'b1;
                p         <= acc_sum[16] ? 16'hFFFF : acc_sum[15:0];
                ovf       <= acc_sum[16];
              end
            end
          end
          DONE: begin
            if (out_ready) begin
              out_valid <= 1'b0;
              state     <= IDLE;
            end
          end
          IDLE:    ;
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule
